// File: rtl/alu_reg_sequencer_pkg.sv
// Shared types and constants for the ALU load sequencer.
// Stage enum, LED one-hot codes and hold-off counter width.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_A,
      WAIT_B,
      WAIT_OP,
      SHOW_RES
   } seq_state_t;

   localparam logic [3:0] LED_WAIT_A   = 4'b0001;
   localparam logic [3:0] LED_WAIT_B   = 4'b0010;
   localparam logic [3:0] LED_WAIT_OP  = 4'b0100;
   localparam logic [3:0] LED_SHOW_RES = 4'b1000;

   localparam int HOLD_W = 8;

   function automatic logic [3:0] led_of(
      input seq_state_t s
   );
      logic [3:0] v;
      v = LED_WAIT_A;
      unique case (s)
         WAIT_A:   v = LED_WAIT_A;
         WAIT_B:   v = LED_WAIT_B;
         WAIT_OP:  v = LED_WAIT_OP;
         SHOW_RES: v = LED_SHOW_RES;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/alu_reg_sequencer_if.sv
// Button/switch inputs and alu_reg drive bundle.
// slave = sequencer side, master = stimulus side.
interface alu_reg_sequencer_if #(
   parameter int N = 16
);

   logic [N-1:0] sw;
   logic         enter;
   logic         undo;
   logic [N-1:0] data_in;
   logic         load_A;
   logic         load_B;
   logic         load_Op;
   logic         updateRes;
   logic [3:0]   state_leds;
   logic         busy;

   modport slave (
      input  sw,
      input  enter,
      input  undo,
      output data_in,
      output load_A,
      output load_B,
      output load_Op,
      output updateRes,
      output state_leds,
      output busy
   );

   modport master (
      output sw,
      output enter,
      output undo,
      input  data_in,
      input  load_A,
      input  load_B,
      input  load_Op,
      input  updateRes,
      input  state_leds,
      input  busy
   );

endinterface

// File: rtl/alu_reg_sequencer_rise_pulse.sv
// Rising-edge detector: one-cycle pulse per low-to-high level change.
// Ports: clk, rst_n (async active-low), i_lvl in, o_pulse out.
module rise_pulse (
   input  logic clk,
   input  logic rst_n,
   input  logic i_lvl,
   output logic o_pulse
);

   logic r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_q <= 1'b0;
      else        r_q <= i_lvl;
   end

   assign o_pulse = i_lvl & ~r_q;

endmodule

// File: rtl/alu_reg_sequencer.sv
// Enter/Undo driven load sequencer for alu_reg: A, B, opcode, result.
// Ports: clk, reset (async active-low), io_bus (switches, buttons, loads, LEDs).
module alu_reg_sequencer
   import alu_seq_pkg::*;
#(
   parameter int N       = 16,
   parameter int HOLDOFF = 8
) (
   input logic              clk,
   input logic              reset,
   alu_reg_sequencer_if.slave io_bus
);

   localparam logic [HOLD_W-1:0] HOLD_LD = HOLDOFF[HOLD_W-1:0];

   seq_state_t        r_state;
   seq_state_t        w_state_nxt;
   logic [N-1:0]      r_data;
   logic [N-1:0]      w_data_nxt;
   logic              r_ld_a;
   logic              r_ld_b;
   logic              r_ld_op;
   logic              w_ld_a;
   logic              w_ld_b;
   logic              w_ld_op;
   logic [HOLD_W-1:0] r_cnt;
   logic [HOLD_W-1:0] w_cnt_nxt;
   logic              r_upd;
   logic              r_busy;

   logic w_enter_p;
   logic w_undo_p;
   logic w_idle;
   logic w_acc_undo;
   logic w_acc_enter;

   rise_pulse u_enter (
      .clk     (clk),
      .rst_n   (reset),
      .i_lvl   (io_bus.enter),
      .o_pulse (w_enter_p)
   );

   rise_pulse u_undo (
      .clk     (clk),
      .rst_n   (reset),
      .i_lvl   (io_bus.undo),
      .o_pulse (w_undo_p)
   );

   assign w_idle      = (r_cnt == '0);
   // Undo has priority: a coincident enter edge is dropped.
   assign w_acc_undo  = w_undo_p & w_idle;
   assign w_acc_enter = w_enter_p & w_idle & ~w_undo_p;

   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_ld_a      = 1'b0;
      w_ld_b      = 1'b0;
      w_ld_op     = 1'b0;
      w_cnt_nxt   = w_idle ? r_cnt : r_cnt - 1'b1;
      if (w_acc_undo) begin
         w_cnt_nxt = HOLD_LD;
         unique case (r_state)
            WAIT_A:   w_state_nxt = WAIT_A;
            WAIT_B:   w_state_nxt = WAIT_A;
            WAIT_OP:  w_state_nxt = WAIT_B;
            SHOW_RES: w_state_nxt = WAIT_OP;
         endcase
      end else if (w_acc_enter) begin
         w_cnt_nxt = HOLD_LD;
         unique case (r_state)
            WAIT_A: begin
               w_ld_a      = 1'b1;
               w_data_nxt  = io_bus.sw;
               w_state_nxt = WAIT_B;
            end
            WAIT_B: begin
               w_ld_b      = 1'b1;
               w_data_nxt  = io_bus.sw;
               w_state_nxt = WAIT_OP;
            end
            WAIT_OP: begin
               w_ld_op     = 1'b1;
               w_data_nxt  = io_bus.sw;
               w_state_nxt = SHOW_RES;
            end
            SHOW_RES: begin
               w_state_nxt = WAIT_A;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= WAIT_A;
         r_data  <= '0;
         r_ld_a  <= 1'b0;
         r_ld_b  <= 1'b0;
         r_ld_op <= 1'b0;
         r_cnt   <= '0;
         r_upd   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_data  <= w_data_nxt;
         r_ld_a  <= w_ld_a;
         r_ld_b  <= w_ld_b;
         r_ld_op <= w_ld_op;
         r_cnt   <= w_cnt_nxt;
         // Registered from next values so they track r_state/r_cnt.
         r_upd   <= (w_state_nxt == SHOW_RES);
         r_busy  <= (w_cnt_nxt != '0);
      end
   end

   assign io_bus.data_in    = r_data;
   assign io_bus.load_A     = r_ld_a;
   assign io_bus.load_B     = r_ld_b;
   assign io_bus.load_Op    = r_ld_op;
   assign io_bus.updateRes  = r_upd;
   assign io_bus.state_leds = led_of(r_state);
   assign io_bus.busy       = r_busy;

   a_one_load: assert property (
      @(posedge clk) disable iff (!reset)
      $onehot0({r_ld_a, r_ld_b, r_ld_op})
   );

endmodule
